// File: rtl/ttc_stream_gen.sv
// ttc_stream_gen: serialises fixed-width TTC frames onto a single-bit line, MSB first.
// A preamble of sync frames is sent first, then data, idle or counter frames with
// periodic sync re-insertion. The next frame is chosen on the last bit of the current one.
module ttc_stream_gen #(
    parameter int unsigned        FRAME_W       = 16,
    parameter logic [FRAME_W-1:0] SYNC_PATTERN  = 16'h817E,
    parameter logic [FRAME_W-1:0] IDLE_PATTERN  = 16'h6969,
    parameter int unsigned        LOCK_FRAMES   = 46,
    parameter int unsigned        SYNC_INTERVAL = 32,
    parameter logic [FRAME_W-1:0] CNT_SEED      = 16'hAA6A
) (
    input  logic               clk160,
    input  logic               rst,
    input  logic               mode,
    input  logic               restart,
    input  logic [FRAME_W-1:0] word_data,
    input  logic               word_valid,
    output logic               word_ready,
    output logic               ttc_data,
    output logic               frame_start,
    output logic [1:0]         frame_type,
    output logic               locked
);

    localparam int unsigned BIT_W  = $clog2(FRAME_W);
    localparam int unsigned LOCK_W = $clog2(LOCK_FRAMES + 1);
    localparam int unsigned GAP_W  = (SYNC_INTERVAL < 2) ? 1 : $clog2(SYNC_INTERVAL + 1);

    typedef enum logic {
        LOCK = 1'b0,
        RUN  = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        TYPE_SYNC  = 2'd0,
        TYPE_DATA  = 2'd1,
        TYPE_IDLE  = 2'd2,
        TYPE_COUNT = 2'd3
    } ftype_t;

    state_t             state_q, state_d;
    logic [FRAME_W-1:0] shreg_q, shreg_d;
    logic [BIT_W-1:0]   bitCnt_q, bitCnt_d;
    logic [LOCK_W-1:0]  lockCnt_q, lockCnt_d;
    logic [GAP_W-1:0]   gapCnt_q, gapCnt_d;
    logic [GAP_W-1:0]   gapBase;
    logic [FRAME_W-1:0] cnt_q, cnt_d;
    ftype_t             typeStage_q, typeStage_d;
    logic               lockedStage_q, lockedStage_d;
    logic               ttcData_q;
    logic               frameStart_q;
    logic [1:0]         frameType_q;
    logic               locked_q;
    logic               boundary;

    assign boundary = (bitCnt_q == BIT_W'(FRAME_W - 1));
    assign bitCnt_d = boundary ? '0 : bitCnt_q + BIT_W'(1);

    // Entering RUN restarts the sync spacing, so the gap seen on that boundary is zero.
    assign gapBase = (state_q == LOCK) ? '0 : gapCnt_q;

    assign ttc_data    = ttcData_q;
    assign frame_start = frameStart_q;
    assign frame_type  = frameType_q;
    assign locked      = locked_q;

    // Next-frame selection by priority on the boundary bit; shift the frame out otherwise.
    always_comb begin
        state_d       = state_q;
        shreg_d       = {shreg_q[FRAME_W-2:0], 1'b0};
        lockCnt_d     = lockCnt_q;
        gapCnt_d      = gapCnt_q;
        cnt_d         = cnt_q;
        typeStage_d   = typeStage_q;
        lockedStage_d = lockedStage_q;
        word_ready    = 1'b0;
        if (boundary) begin
            if (restart) begin
                state_d       = LOCK;
                lockCnt_d     = LOCK_W'(1);
                shreg_d       = SYNC_PATTERN;
                typeStage_d   = TYPE_SYNC;
                lockedStage_d = 1'b0;
            end else if ((state_q == LOCK) && (lockCnt_q != LOCK_W'(LOCK_FRAMES))) begin
                lockCnt_d     = lockCnt_q + LOCK_W'(1);
                shreg_d       = SYNC_PATTERN;
                typeStage_d   = TYPE_SYNC;
                lockedStage_d = 1'b0;
            end else begin
                state_d       = RUN;
                lockedStage_d = 1'b1;
                if ((SYNC_INTERVAL != 0) && (gapBase == GAP_W'(SYNC_INTERVAL))) begin
                    shreg_d     = SYNC_PATTERN;
                    typeStage_d = TYPE_SYNC;
                    gapCnt_d    = '0;
                end else begin
                    gapCnt_d = gapBase + GAP_W'(1);
                    if (mode) begin
                        shreg_d     = cnt_q;
                        typeStage_d = TYPE_COUNT;
                        cnt_d       = cnt_q + FRAME_W'(1);
                    end else begin
                        word_ready = 1'b1;
                        if (word_valid) begin
                            shreg_d     = word_data;
                            typeStage_d = TYPE_DATA;
                        end else begin
                            shreg_d     = IDLE_PATTERN;
                            typeStage_d = TYPE_IDLE;
                        end
                    end
                end
            end
        end
    end

    // LOCK/RUN state register.
    always_ff @(posedge clk160 or posedge rst) begin
        if (rst) begin
            state_q <= LOCK;
        end else begin
            state_q <= state_d;
        end
    end

    // Frame datapath: shift register, bit position, preamble/gap counters and counter source.
    always_ff @(posedge clk160 or posedge rst) begin
        if (rst) begin
            shreg_q       <= SYNC_PATTERN;
            bitCnt_q      <= '0;
            lockCnt_q     <= LOCK_W'(1);
            gapCnt_q      <= '0;
            cnt_q         <= CNT_SEED;
            typeStage_q   <= TYPE_SYNC;
            lockedStage_q <= 1'b0;
        end else begin
            shreg_q       <= shreg_d;
            bitCnt_q      <= bitCnt_d;
            lockCnt_q     <= lockCnt_d;
            gapCnt_q      <= gapCnt_d;
            cnt_q         <= cnt_d;
            typeStage_q   <= typeStage_d;
            lockedStage_q <= lockedStage_d;
        end
    end

    // Serial output and per-frame flags; type and lock status change together with the MSB.
    always_ff @(posedge clk160 or posedge rst) begin
        if (rst) begin
            ttcData_q    <= 1'b0;
            frameStart_q <= 1'b0;
            frameType_q  <= 2'd0;
            locked_q     <= 1'b0;
        end else begin
            ttcData_q    <= shreg_q[FRAME_W-1];
            frameStart_q <= (bitCnt_q == '0);
            if (bitCnt_q == '0) begin
                frameType_q <= typeStage_q;
                locked_q    <= lockedStage_q;
            end
        end
    end

endmodule

// File: tb/tb_ttc_stream_gen.sv
// tb_ttc_stream_gen: frame-level checks of ttc_stream_gen against a behavioural frame model.
module tb_ttc_stream_gen;

    localparam int          FW       = 16;
    localparam int          LOCKN    = 46;
    localparam int          INTERVAL = 32;
    localparam logic [15:0] SYNC     = 16'h817E;
    localparam logic [15:0] IDLE     = 16'h6969;
    localparam logic [15:0] SEED     = 16'hAA6A;
    localparam logic [15:0] SEED2    = 16'hFFF0;

    typedef struct {
        logic [15:0] value;
        logic [1:0]  ftype;
        logic        lockedFlag;
    } frame_t;

    typedef struct {
        int          rep;
        logic        md;
        logic        vl;
        logic [15:0] dt;
        logic [15:0] expVal;
        logic [1:0]  expType;
        logic        expLocked;
        logic        expRdy;
    } vec_t;

    logic        clk160 = 1'b0;
    logic        rst, rst2;
    logic        mode, restart, word_valid;
    logic [15:0] word_data;
    logic        word_ready, ttc_data, frame_start, locked;
    logic [1:0]  frame_type;
    logic        mode2, restart2, word_valid2;
    logic [15:0] word_data2;
    logic        word_ready2, ttc_data2, frame_start2, locked2;
    logic [1:0]  frame_type2;

    int checks = 0;
    int errors = 0;

    // Frame-level model: preamble frames still owed, whether RUN was reached,
    // non-sync frames since the last sync, and the counter source.
    int          mPreLeft;
    bit          mRunning;
    int          mSince;
    logic [15:0] mCtr;

    int          cycCount;
    int          riseCycle;
    bit          riseSeen;

    vec_t        vecs[13];
    frame_t      cur, nxt, seen;
    logic        rdy;
    int          syncRun;
    bit          done;
    bit          havePend;
    logic [15:0] pend;
    logic        rs, md;
    logic [15:0] bits2, expV, prevV;
    logic [1:0]  type2;
    logic        lock2, start2, rdy2Ok;
    int          syncAfter;
    bit          wrapSeen;

    always #5 clk160 = ~clk160;

    ttc_stream_gen dut (
        .clk160      (clk160),
        .rst         (rst),
        .mode        (mode),
        .restart     (restart),
        .word_data   (word_data),
        .word_valid  (word_valid),
        .word_ready  (word_ready),
        .ttc_data    (ttc_data),
        .frame_start (frame_start),
        .frame_type  (frame_type),
        .locked      (locked)
    );

    ttc_stream_gen #(
        .SYNC_INTERVAL (0),
        .CNT_SEED      (16'hFFF0)
    ) dut2 (
        .clk160      (clk160),
        .rst         (rst2),
        .mode        (mode2),
        .restart     (restart2),
        .word_data   (word_data2),
        .word_valid  (word_valid2),
        .word_ready  (word_ready2),
        .ttc_data    (ttc_data2),
        .frame_start (frame_start2),
        .frame_type  (frame_type2),
        .locked      (locked2)
    );

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic modelReset();
        mPreLeft = LOCKN - 1;
        mRunning = 1'b0;
        mSince   = 0;
        mCtr     = SEED;
    endtask

    // Chooses the frame that follows the current one, given the boundary inputs.
    task automatic modelStep(input logic rsIn, input logic mdIn, input logic vlIn,
                             input logic [15:0] dtIn, output frame_t f, output logic ready);
        ready = 1'b0;
        if (rsIn) begin
            mPreLeft = LOCKN - 1;
            mRunning = 1'b0;
            f = '{SYNC, 2'd0, 1'b0};
        end else if (mPreLeft > 0) begin
            mPreLeft--;
            f = '{SYNC, 2'd0, 1'b0};
        end else begin
            if (!mRunning) begin
                mRunning = 1'b1;
                mSince   = 0;
            end
            if (INTERVAL != 0 && mSince == INTERVAL) begin
                mSince = 0;
                f = '{SYNC, 2'd0, 1'b1};
            end else begin
                mSince++;
                if (mdIn) begin
                    f = '{mCtr, 2'd3, 1'b1};
                    mCtr = mCtr + 16'd1;
                end else begin
                    ready = 1'b1;
                    f = vlIn ? '{dtIn, 2'd1, 1'b1} : '{IDLE, 2'd2, 1'b1};
                end
            end
        end
    endtask

    // Observes one frame of the main DUT, applying the boundary inputs on its last bit
    // and scrambling them elsewhere in the frame.
    task automatic applyStimulus(input frame_t exp, input logic rsIn, input logic mdIn,
                                 input logic vlIn, input logic [15:0] dtIn, input logic expRdy,
                                 input string tag, output frame_t obs);
        logic [15:0] bits;
        logic [1:0]  typeMsb;
        logic        lockMsb;
        logic        startOk, steadyOk, idleRdyOk;
        bits = '0; typeMsb = '0; lockMsb = 1'b0;
        startOk = 1'b1; steadyOk = 1'b1; idleRdyOk = 1'b1;
        for (int j = 0; j < FW; j++) begin
            @(posedge clk160);
            #1;
            bits = {bits[14:0], ttc_data};
            if (j == 0) begin
                typeMsb = frame_type;
                lockMsb = locked;
            end else if (frame_type !== typeMsb || locked !== lockMsb) begin
                steadyOk = 1'b0;
            end
            if (frame_start !== (j == 0)) startOk = 1'b0;
            if (locked === 1'b1 && !riseSeen) begin
                riseSeen  = 1'b1;
                riseCycle = cycCount;
            end
            cycCount++;
            if (j == FW - 2) begin
                restart = rsIn; mode = mdIn; word_valid = vlIn; word_data = dtIn;
                #1;
                checkOutput({tag, " word_ready"}, 32'(word_ready), 32'(expRdy));
            end else begin
                if (word_ready !== 1'b0) idleRdyOk = 1'b0;
                if (j == FW - 1) begin
                    restart    = 1'($urandom_range(0, 1));
                    mode       = 1'($urandom_range(0, 1));
                    word_valid = 1'($urandom_range(0, 1));
                    word_data  = 16'($urandom);
                end
            end
        end
        checkOutput({tag, " value"}, 32'(bits), 32'(exp.value));
        checkOutput({tag, " frame_type"}, 32'(typeMsb), 32'(exp.ftype));
        checkOutput({tag, " locked"}, 32'(lockMsb), 32'(exp.lockedFlag));
        checkOutput({tag, " frame_start"}, 32'(startOk), 32'd1);
        checkOutput({tag, " steady flags"}, 32'(steadyOk), 32'd1);
        checkOutput({tag, " ready mid-frame"}, 32'(idleRdyOk), 32'd1);
        obs = '{bits, typeMsb, lockMsb};
    endtask

    // Runs the preamble plus the first frame after it from a fresh release.
    task automatic runPreamble(input string tag);
        cycCount  = 0;
        riseSeen  = 1'b0;
        riseCycle = -1;
        modelReset();
        cur = '{SYNC, 2'd0, 1'b0};
        for (int k = 0; k <= LOCKN; k++) begin
            modelStep(1'b0, 1'b0, 1'b0, 16'h0, nxt, rdy);
            applyStimulus(cur, 1'b0, 1'b0, 1'b0, 16'h0, rdy, tag, seen);
            cur = nxt;
        end
        checkOutput({tag, " lock rise cycle"}, 32'(riseCycle), 32'(LOCKN * FW));
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0]  = '{1,  1'b0, 1'b1, 16'h1234, 16'h1234, 2'd1, 1'b1, 1'b1};
        vecs[1]  = '{1,  1'b0, 1'b1, 16'h5678, 16'h5678, 2'd1, 1'b1, 1'b1};
        vecs[2]  = '{1,  1'b0, 1'b0, 16'h0000, 16'h6969, 2'd2, 1'b1, 1'b1};
        vecs[3]  = '{1,  1'b1, 1'b0, 16'h0000, 16'hAA6A, 2'd3, 1'b1, 1'b0};
        vecs[4]  = '{1,  1'b1, 1'b0, 16'h0000, 16'hAA6B, 2'd3, 1'b1, 1'b0};
        vecs[5]  = '{25, 1'b0, 1'b0, 16'h0000, 16'h6969, 2'd2, 1'b1, 1'b1};
        vecs[6]  = '{1,  1'b0, 1'b1, 16'hBEEF, 16'h817E, 2'd0, 1'b1, 1'b0};
        vecs[7]  = '{1,  1'b0, 1'b1, 16'hBEEF, 16'hBEEF, 2'd1, 1'b1, 1'b1};
        vecs[8]  = '{1,  1'b1, 1'b0, 16'h0000, 16'hAA6C, 2'd3, 1'b1, 1'b0};
        vecs[9]  = '{1,  1'b1, 1'b0, 16'h0000, 16'hAA6D, 2'd3, 1'b1, 1'b0};
        vecs[10] = '{29, 1'b0, 1'b0, 16'h0000, 16'h6969, 2'd2, 1'b1, 1'b1};
        vecs[11] = '{1,  1'b1, 1'b0, 16'h0000, 16'h817E, 2'd0, 1'b1, 1'b0};
        vecs[12] = '{1,  1'b1, 1'b1, 16'hDEAD, 16'hAA6E, 2'd3, 1'b1, 1'b0};

        rst = 1'b1; rst2 = 1'b1;
        restart = 1'b0; mode = 1'b0; word_valid = 1'b0; word_data = 16'h0;
        mode2 = 1'b1; restart2 = 1'b0; word_valid2 = 1'b0; word_data2 = 16'h0;

        repeat (3) @(posedge clk160);
        #1;
        checkOutput("reset ttc_data", 32'(ttc_data), 32'd0);
        checkOutput("reset frame_start", 32'(frame_start), 32'd0);
        checkOutput("reset frame_type", 32'(frame_type), 32'd0);
        checkOutput("reset locked", 32'(locked), 32'd0);
        checkOutput("reset word_ready", 32'(word_ready), 32'd0);

        @(negedge clk160);
        rst = 1'b0;
        runPreamble("preamble");

        for (int r = 0; r < 13; r++) begin
            for (int n = 0; n < vecs[r].rep; n++) begin
                modelStep(1'b0, vecs[r].md, vecs[r].vl, vecs[r].dt, nxt, rdy);
                applyStimulus(cur, 1'b0, vecs[r].md, vecs[r].vl, vecs[r].dt, vecs[r].expRdy,
                              $sformatf("vec%0d", r), seen);
                cur = '{vecs[r].expVal, vecs[r].expType, vecs[r].expLocked};
            end
        end

        // Restart held over a boundary in RUN: the frame on the line completes first.
        modelStep(1'b1, 1'b0, 1'b0, 16'h0, nxt, rdy);
        applyStimulus(cur, 1'b1, 1'b0, 1'b0, 16'h0, rdy, "restart request", seen);
        cur = nxt;
        syncRun = 0;
        done = 1'b0;
        for (int k = 0; k < 60 && !done; k++) begin
            modelStep(1'b0, 1'b0, 1'b1, 16'hC0DE, nxt, rdy);
            applyStimulus(cur, 1'b0, 1'b0, 1'b1, 16'hC0DE, rdy, "restart", seen);
            if (k == 0) checkOutput("locked on first restart sync", 32'(seen.lockedFlag), 32'd0);
            if (seen.ftype == 2'd0 && seen.value == SYNC) begin
                syncRun++;
            end else begin
                done = 1'b1;
                checkOutput("word after restart", 32'(seen.value), 32'hC0DE);
            end
            cur = nxt;
        end
        checkOutput("restart sync count", 32'(syncRun), 32'(LOCKN));

        // Reset in the middle of a locked frame.
        repeat (5) @(posedge clk160);
        #1;
        checkOutput("locked before mid reset", 32'(locked), 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("mid reset ttc_data", 32'(ttc_data), 32'd0);
        checkOutput("mid reset frame_start", 32'(frame_start), 32'd0);
        checkOutput("mid reset locked", 32'(locked), 32'd0);
        checkOutput("mid reset frame_type", 32'(frame_type), 32'd0);
        restart = 1'b0; mode = 1'b0; word_valid = 1'b0;
        @(negedge clk160);
        rst = 1'b0;
        runPreamble("post-reset preamble");

        // Randomised traffic with a word source that holds each word until accepted.
        havePend = 1'b0;
        pend = 16'h0;
        for (int k = 0; k < 300; k++) begin
            rs = ($urandom_range(0, 149) == 0);
            md = ($urandom_range(0, 3) == 0);
            if (!havePend && $urandom_range(0, 2) != 0) begin
                havePend = 1'b1;
                pend = 16'($urandom);
            end
            modelStep(rs, md, havePend, pend, nxt, rdy);
            applyStimulus(cur, rs, md, havePend, pend, rdy, "random", seen);
            if (rdy && havePend) havePend = 1'b0;
            cur = nxt;
        end

        // Second instance: counter mode, no re-inserted syncs, seed near the top.
        @(negedge clk160);
        rst2 = 1'b0;
        syncAfter = 0;
        wrapSeen = 1'b0;
        prevV = 16'h0;
        for (int k = 0; k < LOCKN + 200; k++) begin
            bits2 = '0; type2 = '0; lock2 = 1'b0; start2 = 1'b0; rdy2Ok = 1'b1;
            for (int j = 0; j < FW; j++) begin
                @(posedge clk160);
                #1;
                bits2 = {bits2[14:0], ttc_data2};
                if (j == 0) begin
                    type2 = frame_type2; lock2 = locked2; start2 = frame_start2;
                end
                if (word_ready2 !== 1'b0) rdy2Ok = 1'b0;
            end
            if (k < LOCKN) begin
                checkOutput("cnt preamble value", 32'(bits2), 32'(SYNC));
                checkOutput("cnt preamble type", 32'(type2), 32'd0);
            end else begin
                expV = SEED2 + 16'(k - LOCKN);
                checkOutput("cnt value", 32'(bits2), 32'(expV));
                checkOutput("cnt type", 32'(type2), 32'd3);
                checkOutput("cnt locked", 32'(lock2), 32'd1);
                if (type2 == 2'd0) syncAfter++;
                if (k > LOCKN && prevV == 16'hFFFF && bits2 == 16'h0000) wrapSeen = 1'b1;
            end
            checkOutput("cnt frame_start", 32'(start2), 32'd1);
            checkOutput("cnt word_ready", 32'(rdy2Ok), 32'd1);
            prevV = bits2;
        end
        checkOutput("cnt syncs after preamble", 32'(syncAfter), 32'd0);
        checkOutput("cnt wrap FFFF->0000", 32'(wrapSeen), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ttc_stream_gen.md
# ttc_stream_gen

Synthesizable TTC command-stream generator that serialises fixed-width frames onto a single-bit line at one bit per clock. It replaces the bench-only TTC stimulus used to drive RD53_top: it emits a parametrised lock preamble of sync frames, then runtime data frames with periodic sync re-insertion. Data comes either from an external valid/ready word stream or from an internal incrementing counter. It sits in the 160 MHz domain, in front of the TTC input of the emulator, in both benches and hardware loopback.

## Interface
- FRAME_W, 16: frame width in bits (≥4).
- SYNC_PATTERN, 16'h817E: sync frame value, FRAME_W bits.
- IDLE_PATTERN, 16'h6969: frame sent when no data is available.
- LOCK_FRAMES, 46: sync frames in the preamble (≥1).
- SYNC_INTERVAL, 32: non-sync frames between re-inserted syncs; 0 disables re-insertion.
- CNT_SEED, 16'hAA6A: counter-mode start value.

Ports:
- clk160  in  1  serial bit clock.
- rst  in  1  asynchronous, active-high reset.
- mode  in  1  0 = external stream, 1 = internal counter; sampled at frame boundary.
- restart  in  1  request to re-run the lock preamble; sampled at frame boundary.
- word_data  in  FRAME_W  external frame value.
- word_valid  in  1  word_data valid.
- word_ready  out  1  combinational; the word is consumed on an edge where valid&&ready.
- ttc_data  out  1  registered serial output, MSB first.
- frame_start  out  1  registered; high while ttc_data carries a frame MSB.
- frame_type  out  2  registered; 0 sync, 1 data, 2 idle, 3 counter; valid for the whole frame.
- locked  out  1  registered; high in RUN.

## Operation
- State: shreg[FRAME_W-1:0], bit_cnt (0..FRAME_W-1), FSM {LOCK, RUN}, lock_cnt, gap_cnt, cnt_reg.
- Every edge: ttc_data<=shreg[MSB]; bit_cnt increments, wrapping at FRAME_W-1. frame_start<=(bit_cnt==0).
- When bit_cnt≠FRAME_W-1: shreg<<=1.
- Boundary edge (bit_cnt==FRAME_W-1): shreg<=next frame and frame_type is staged for it. The next frame is chosen by this priority:
  1. restart=1: FSM→LOCK, lock_cnt←1, send sync.
  2. FSM=LOCK and lock_cnt<LOCK_FRAMES: send sync, lock_cnt++.
  3. FSM=LOCK and lock_cnt==LOCK_FRAMES: FSM→RUN, gap_cnt←0, then fall through to rule 4.
  4. RUN and SYNC_INTERVAL≠0 and gap_cnt==SYNC_INTERVAL: send sync, gap_cnt←0.
  5. RUN and mode=1: send cnt_reg, cnt_reg←cnt_reg+1 (wraps mod 2^FRAME_W), gap_cnt++.
  6. RUN and mode=0 and word_valid: send word_data, gap_cnt++.
  7. Otherwise: send IDLE_PATTERN, gap_cnt++.
- word_ready=1 only on a boundary cycle where rule 6 or 7 would be selected; it is 0 in LOCK, on sync slots and in counter mode. Words are never dropped: a valid word held across a sync slot is sent in the following slot.
- locked is high from the first non-sync RUN frame. It drops in the cycle that frame's MSB appears for a restart-selected frame.
- cnt_reg is not reset by restart or mode changes; only rst reloads CNT_SEED.

## Timing
- Reset values: shreg=SYNC_PATTERN, bit_cnt=0, FSM=LOCK, lock_cnt=1, gap_cnt=0, cnt_reg=CNT_SEED, ttc_data=0, frame_start=0, frame_type=0, locked=0.
- First edge after rst release: ttc_data=SYNC_PATTERN[MSB], frame_start=1. Frames are back-to-back, exactly FRAME_W cycles each, with no gap.
- Latency from the boundary sampling edge to the frame MSB on ttc_data is 1 cycle.
- The preamble is exactly LOCK_FRAMES×FRAME_W cycles.
- rst mid-frame aborts the frame immediately; all state returns to reset values.
- restart, mode and word_valid are only examined on boundary edges. Toggling them mid-frame has no effect.

## Test plan
- Defaults, mode=0, word_valid=0: 46 frames of 16'h817E, then 16'h6969 repeatedly, with a 16'h817E after every 32 idles. locked rises at cycle 46×16 after release.
- mode=1: post-lock frames are 16'hAA6A, AA6B, AA6C, … One sync is inserted every 32 counter frames; the counter does not advance on sync slots.
- mode=0, word_valid held with words 0x1234, 0x5678: each word appears once, in order. word_ready pulses once per accepted word. A word due on a sync slot is delayed one frame, not lost.
- SYNC_INTERVAL=0 and counter mode run for 200 frames: no sync after the preamble. The counter wraps 16'hFFFF→16'h0000 when the seed is set near the top.
- restart pulse mid-frame in RUN: the current frame completes, then 46 syncs follow, then data resumes. locked drops on the first restart sync.
- rst asserted mid-frame: ttc_data=0, frame_start=0 and locked=0 immediately. After release the preamble restarts from sync frame 1.
